// File: rtl/pmp_gate.sv
// Request gate between core port and system bus: every request is checked by the PMP
// checker first; denied ones get a fault response and never reach the bus. Option: PMP_GATE_TIMEOUT_EN.
module pmp_gate #(
    parameter logic [1:0] M_MODE  = 2'b11,
    parameter int         TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [1:0]  mem_mode,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        pmp_valid,
    output logic        pmp_instr,
    output logic [1:0]  pmp_mode,
    output logic [31:0] pmp_addr,
    output logic [3:0]  pmp_wstrb,
    input  logic        pmp_error,
    output logic        bus_valid,
    output logic        bus_instr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [7:0]  fault_count
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, RESP, FAULT} state_t;

    state_t      state;
    logic        req_instr;
    logic [1:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] rdata_q;

`ifdef PMP_GATE_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            req_instr   <= 1'b0;
            req_mode    <= 2'b00;
            req_addr    <= 32'h0;
            req_wdata   <= 32'h0;
            req_wstrb   <= 4'h0;
            rdata_q     <= 32'h0;
            fault_count <= 8'h00;
`ifdef PMP_GATE_TIMEOUT_EN
            wait_cnt    <= 16'h0;
`endif
        end else begin
            case (state)
                IDLE: if (mem_valid) begin
                    req_instr <= mem_instr;
                    req_mode  <= mem_mode;
                    req_addr  <= mem_addr;
                    req_wdata <= mem_wdata;
                    req_wstrb <= mem_wstrb;
                    state     <= CHECK;
                end
                CHECK: begin
                    if (pmp_error) begin
                        rdata_q <= 32'h0;  // fault cycle must present zero data
                        state   <= FAULT;
                    end else begin
                        state   <= ISSUE;
                    end
`ifdef PMP_GATE_TIMEOUT_EN
                    wait_cnt <= 16'h0;
`endif
                end
                ISSUE: begin
                    if (bus_ready) begin
                        rdata_q <= bus_rdata;
                        state   <= RESP;
                    end
`ifdef PMP_GATE_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        rdata_q <= 32'h0;
                        state   <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'h1;
                    end
`endif
                end
                RESP: state <= IDLE;
                FAULT: begin
                    if (fault_count != 8'hFF)
                        fault_count <= fault_count + 8'h01;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and checker views are pure decodes of state and latched request.
    always_comb begin
        mem_ready = (state == RESP) || (state == FAULT);
        mem_error = (state == FAULT);
        mem_rdata = rdata_q;
        pmp_valid = (state == CHECK);
        pmp_instr = pmp_valid & req_instr;
        pmp_mode  = pmp_valid ? req_mode  : 2'b00;
        pmp_addr  = pmp_valid ? req_addr  : 32'h0;
        pmp_wstrb = pmp_valid ? req_wstrb : 4'h0;
        bus_valid = (state == ISSUE);
        bus_instr = bus_valid & req_instr;
        bus_addr  = bus_valid ? req_addr  : 32'h0;
        bus_wdata = bus_valid ? req_wdata : 32'h0;
        bus_wstrb = bus_valid ? req_wstrb : 4'h0;
    end
endmodule

// File: tb/tb_pmp_gate.sv
// Randomized bench for pmp_gate; acts as PMP checker and bus, compares against a
// transaction-level model of expected responses and fault count.
module tb_pmp_gate;
`ifdef PMP_GATE_TIMEOUT_EN
    localparam int TO = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0, mem_instr = 1'b0;
    logic [1:0]  mem_mode = 2'b00;
    logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready, mem_error;
    logic [31:0] mem_rdata;
    logic        pmp_valid, pmp_instr, pmp_error;
    logic [1:0]  pmp_mode;
    logic [31:0] pmp_addr;
    logic [3:0]  pmp_wstrb;
    logic        bus_valid, bus_instr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic [7:0]  fault_count;

    int total = 0, bad = 0, exp_faults = 0;

    always #5 clock = ~clock;

    // Checker policy: non-machine code may only touch the upper half of memory.
    assign pmp_error = pmp_valid && !pmp_addr[31] && (pmp_mode != 2'b11);

    pmp_gate #(.M_MODE(2'b11), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_mode(mem_mode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .pmp_valid(pmp_valid), .pmp_instr(pmp_instr), .pmp_mode(pmp_mode),
        .pmp_addr(pmp_addr), .pmp_wstrb(pmp_wstrb), .pmp_error(pmp_error),
        .bus_valid(bus_valid), .bus_instr(bus_instr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .fault_count(fault_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic bump_faults();
        if (exp_faults < 255) exp_faults++;
    endtask

    // One complete core transaction; wait_n = extra ISSUE cycles before bus_ready.
    task automatic run_txn(input logic instr, input logic [1:0] mode, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int wait_n, input logic [31:0] rd, input bit extra);
        bit deny, tmo;
        int n;
        deny = (addr < 32'h8000_0000) && (mode != 2'b11);
        mem_valid = 1'b1; mem_instr = instr; mem_mode = mode;
        mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        @(posedge clock); #1;
        mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
        mem_wstrb = 4'($urandom); mem_mode = 2'($urandom); mem_instr = 1'($urandom);
        @(negedge clock);
        chk("check_pmp_valid", 32'(pmp_valid), 1);
        chk("check_pmp_addr", pmp_addr, addr);
        chk("check_pmp_mode", 32'(pmp_mode), 32'(mode));
        chk("check_pmp_wstrb", 32'(pmp_wstrb), 32'(wstrb));
        chk("check_pmp_instr", 32'(pmp_instr), 32'(instr));
        chk("check_bus_valid", 32'(bus_valid), 0);
        chk("check_mem_ready", 32'(mem_ready), 0);
        if (deny) begin
            @(posedge clock); #1;
            @(negedge clock);
            chk("fault_ready", 32'(mem_ready), 1);
            chk("fault_error", 32'(mem_error), 1);
            chk("fault_rdata", mem_rdata, 0);
            chk("fault_bus_valid", 32'(bus_valid), 0);
            chk("fault_bus_addr", bus_addr, 0);
            bump_faults();
        end else begin
            tmo = TO_EN && (wait_n >= TO);
            n = tmo ? TO : wait_n + 1;
            for (int w = 0; w < n; w++) begin
                @(posedge clock); #1;
                bus_ready = !tmo && (w == n - 1);
                bus_rdata = bus_ready ? rd : $urandom;
                mem_valid = extra && (w == 0);
                @(negedge clock);
                chk("issue_bus_valid", 32'(bus_valid), 1);
                chk("issue_bus_addr", bus_addr, addr);
                chk("issue_bus_wdata", bus_wdata, wdata);
                chk("issue_bus_wstrb", 32'(bus_wstrb), 32'(wstrb));
                chk("issue_bus_instr", 32'(bus_instr), 32'(instr));
                chk("issue_mem_ready", 32'(mem_ready), 0);
                chk("issue_pmp_valid", 32'(pmp_valid), 0);
            end
            @(posedge clock); #1;
            bus_ready = 1'b0; mem_valid = 1'b0;
            @(negedge clock);
            chk("resp_ready", 32'(mem_ready), 1);
            chk("resp_error", 32'(mem_error), 32'(tmo));
            chk("resp_rdata", mem_rdata, tmo ? 32'h0 : rd);
            chk("resp_bus_valid", 32'(bus_valid), 0);
            if (tmo) bump_faults();
        end
        @(posedge clock); #1;
        chk("idle_ready", 32'(mem_ready), 0);
        chk("idle_error", 32'(mem_error), 0);
        chk("fault_count", 32'(fault_count), 32'(exp_faults));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; bus_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(mem_ready), 0);
        chk("rst_error", 32'(mem_error), 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_pmp_valid", 32'(pmp_valid), 0);
        chk("rst_bus_valid", 32'(bus_valid), 0);
        chk("rst_fault_count", 32'(fault_count), 0);
        reset = 1'b1;
        // bus_ready while idle must not produce a response
        @(posedge clock); #1;
        @(negedge clock);
        chk("idle_bus_ready", 32'(mem_ready), 0);
        bus_ready = 1'b0;
        @(posedge clock); #1;

        run_txn(1'b0, 2'b00, 32'h8000_0000, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);
        run_txn(1'b0, 2'b00, 32'h0000_1000, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0);
        run_txn(1'b0, 2'b11, 32'h9000_0040, 32'hCAFE_F00D, 4'h3, TO_EN ? 3 : 5, 32'h5555_AAAA, 1'b1);
        run_txn(1'b1, 2'b11, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < 40; i++)
            run_txn(1'($urandom), 2'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, TO_EN ? 5 : 6)), $urandom, 1'($urandom));

        // reset while a bus request is outstanding
        mem_valid = 1'b1; mem_mode = 2'b11; mem_addr = 32'hA000_0000; mem_wstrb = 4'h0;
        @(posedge clock); #1; mem_valid = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_bus_valid", 32'(bus_valid), 1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_faults = 0;
        chk("rst_issue_bus_valid", 32'(bus_valid), 0);
        chk("rst_issue_ready", 32'(mem_ready), 0);
        chk("rst_issue_faults", 32'(fault_count), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("post_rst_ready", 32'(mem_ready), 0);
            chk("post_rst_bus_valid", 32'(bus_valid), 0);
        end
        run_txn(1'b0, 2'b01, 32'hB000_0008, 32'h0, 4'h0, 2, 32'h1357_9BDF, 1'b0);

        if (TO_EN) begin
            run_txn(1'b0, 2'b11, 32'hC000_0000, 32'h0, 4'h0, 4, 32'h1111_1111, 1'b0);
            run_txn(1'b0, 2'b11, 32'hC000_0004, 32'h0, 4'h0, 3, 32'h2222_2222, 1'b0);
        end

        for (int i = 0; i < 260; i++)
            run_txn(1'($urandom), 2'($urandom_range(0, 2)), 32'($urandom) & 32'h7FFF_FFFF,
                    $urandom, 4'($urandom), 0, 32'h0, 1'b0);
        chk("sat_fault_count", 32'(fault_count), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
